// File: rtl/fifo_rr_drain_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain_arbiter_if
//   Groups the signals between the round-robin drain arbiter, the NUM_CH
//   synchronous FIFOs it reads, and the downstream valid/ready consumer.
//
//   Handshake rule for the downstream port: a word moves on a rising clk edge
//   where m_valid & m_ready are both high. Once m_valid rises, m_data and m_ch
//   hold steady until that edge, and m_valid never drops without a transfer
//   except on reset.
//
//   Signals
//     fifo_empty  NUM_CH     per-FIFO empty flag            (FIFO -> arbiter)
//     fifo_rd_en  NUM_CH     per-FIFO read enable, one-hot0 (arbiter -> FIFO)
//     fifo_dout   NUM_CH*DW  registered FIFO outputs        (FIFO -> arbiter)
//     m_data      DW         word delivered downstream
//     m_ch        CW         source FIFO index of m_data
//     m_valid     1          m_data/m_ch valid
//     m_ready     1          downstream can accept
//     busy        1          arbiter is not idle
//
//   Modports
//     master : arbiter side
//     slave  : FIFO bank + consumer side
// -----------------------------------------------------------------------------
interface fifo_rr_drain_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8,
    parameter int CW     = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0]    fifo_empty;
    logic [NUM_CH-1:0]    fifo_rd_en;
    logic [NUM_CH*DW-1:0] fifo_dout;
    logic [DW-1:0]        m_data;
    logic [CW-1:0]        m_ch;
    logic                 m_valid;
    logic                 m_ready;
    logic                 busy;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_ch,
        output m_valid,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_ch,
        input  m_valid,
        input  busy
    );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain_arbiter
//   Shares one downstream consumer between NUM_CH synchronous FIFOs. A
//   non-empty FIFO is picked round-robin, its read enable is pulsed for one
//   cycle, the FIFO's registered output is captured one cycle later and then
//   offered on a valid/ready port. Up to MAX_BURST words are drained from the
//   granted FIFO before the grant rotates.
//
//   Ports
//     clk        in   single clock for arbiter and served FIFOs
//     rst_n      in   asynchronous reset, active low
//     bus        if   master modport of fifo_rr_drain_arbiter_if
//     dbg_state  out  current FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE, 3 HOLD)
//
//   Per word the FSM walks ISSUE (rd_en pulse) -> CAPTURE (FIFO output now
//   valid, register it) -> HOLD (offer downstream), so a burst delivers one
//   word every three cycles with m_ready held high.
// -----------------------------------------------------------------------------
module fifo_rr_drain_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int CW        = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fifo_rr_drain_arbiter_if.master   bus,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cur_ch;
    logic [CW-1:0]   cur_ch_nxt;
    logic [CW-1:0]   last_grant;
    logic [CW-1:0]   last_grant_nxt;
    logic [7:0]      burst_cnt;
    logic [7:0]      burst_cnt_nxt;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   data_nxt;
    logic [CW-1:0]   ch_q;
    logic [CW-1:0]   ch_nxt;
    logic            valid_q;
    logic            valid_nxt;
    logic [DW-1:0]   dout_sel;
    logic [CW-1:0]   rr_choice;
    logic            any_ready;
    logic            burst_room;

    // First non-empty channel after 'last', wrapping modulo NUM_CH.
    // Scanning from the farthest candidate down lets the nearest one win.
    function automatic logic [CW-1:0] rr_pick(
        input logic [NUM_CH-1:0] empty,
        input logic [CW-1:0]     last
    );
        logic [CW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CH;
            if (!empty[idx]) begin
                pick = CW'(idx);
            end
        end
        return pick;
    endfunction

    assign rr_choice  = rr_pick(bus.fifo_empty, last_grant);
    assign any_ready  = (bus.fifo_empty != {NUM_CH{1'b1}});
    assign dout_sel   = bus.fifo_dout[cur_ch*DW +: DW];

    // Room for another word in this grant after the one being accepted now.
    assign burst_room = (({1'b0, burst_cnt} + 9'd1) < 9'(MAX_BURST));

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_ch     <= '0;
            last_grant <= CW'(NUM_CH - 1);
            burst_cnt  <= '0;
            data_q     <= '0;
            ch_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_ch     <= cur_ch_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
            data_q     <= data_nxt;
            ch_q       <= ch_nxt;
            valid_q    <= valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        cur_ch_nxt     = cur_ch;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        data_nxt       = data_q;
        ch_nxt         = ch_q;
        valid_nxt      = valid_q;

        case (state)
            IDLE: begin
                if (any_ready) begin
                    cur_ch_nxt    = rr_choice;
                    burst_cnt_nxt = '0;
                    state_nxt     = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus.fifo_empty[cur_ch]) begin
                    state_nxt = CAPTURE;
                end else begin
                    // Defensive: the FIFO emptied under us; give up the grant.
                    last_grant_nxt = cur_ch;
                    state_nxt      = IDLE;
                end
            end

            CAPTURE: begin
                data_nxt  = dout_sel;
                ch_nxt    = cur_ch;
                valid_nxt = 1'b1;
                state_nxt = HOLD;
            end

            HOLD: begin
                if (valid_q && bus.m_ready) begin
                    valid_nxt     = 1'b0;
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (burst_room && !bus.fifo_empty[cur_ch]) begin
                        state_nxt = ISSUE;
                    end else begin
                        last_grant_nxt = cur_ch;
                        state_nxt      = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-enable decode: only in ISSUE, only the granted FIFO, never an
    // empty one.
    // ------------------------------------------------------------------
    always_comb begin
        bus.fifo_rd_en = '0;
        if (state == ISSUE && !bus.fifo_empty[cur_ch]) begin
            bus.fifo_rd_en[cur_ch] = 1'b1;
        end
    end

    assign bus.m_data  = data_q;
    assign bus.m_ch    = ch_q;
    assign bus.m_valid = valid_q;
    assign bus.busy    = (state != IDLE);
    assign dbg_state   = state;

endmodule
